// File: rtl/alu_div_seq.sv
// alu_div_seq: multi-cycle unsigned 32-bit restoring divider that borrows the
// shared datapath ALU for one trial subtraction per clock.
module alu_div_seq (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        Start,
   input  logic [31:0] Dividend,
   input  logic [31:0] Divisor,
   output logic        Busy,
   output logic        Done,
   output logic [31:0] Quotient,
   output logic [31:0] Remainder,
   output logic        DivByZero,
   output logic [31:0] ALU_Src_A,
   output logic [31:0] ALU_Src_B,
   output logic [1:0]  ALU_Control,
   input  logic [31:0] ALUResult,
   input  logic [3:0]  ALUFlags
);

   localparam int unsigned WIDTH = 32;
   localparam int unsigned CNT_W = 6;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ITER = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             dbz_q, dbz_d;
   logic [WIDTH-1:0] alu_a_q, alu_a_d;
   logic [WIDTH-1:0] alu_b_q, alu_b_d;
   logic [1:0]       alu_ctrl_q, alu_ctrl_d;
   logic [WIDTH-1:0] rs;

   // Only the carry flag participates in the quotient-bit decision.
   logic unused_flags;
   assign unused_flags = ^{ALUFlags[3:2], ALUFlags[0]};

   // Next-state, datapath and registered-output computation.
   // ALU operands are registered one cycle ahead: the value loaded here is the
   // shifted remainder that the following ITER cycle will compare against D.
   always_comb begin
      state_d    = state_q;
      r_d        = r_q;
      q_d        = q_q;
      d_d        = d_q;
      cnt_d      = cnt_q;
      quot_d     = quot_q;
      rem_d      = rem_q;
      dbz_d      = dbz_q;
      alu_a_d    = '0;
      alu_b_d    = '0;
      alu_ctrl_d = ALU_ADD;
      rs         = {r_q[WIDTH-2:0], q_q[WIDTH-1]};

      case (state_q)
         S_IDLE: begin
            if (Start) begin
               if (Divisor != '0) begin
                  state_d    = S_ITER;
                  r_d        = '0;
                  q_d        = Dividend;
                  d_d        = Divisor;
                  cnt_d      = '0;
                  alu_a_d    = {{(WIDTH-1){1'b0}}, Dividend[WIDTH-1]};
                  alu_b_d    = Divisor;
                  alu_ctrl_d = ALU_SUB;
               end else begin
                  state_d = S_DONE;
                  quot_d  = '1;
                  rem_d   = Dividend;
                  dbz_d   = 1'b1;
               end
            end
         end

         S_ITER: begin
            // A set R msb means the shifted value exceeds 2^32 > D; the wrapped
            // ALU difference is still exact because Rs - D < 2^32.
            if (r_q[WIDTH-1] | ALUFlags[1]) begin
               r_d = ALUResult;
               q_d = {q_q[WIDTH-2:0], 1'b1};
            end else begin
               r_d = rs;
               q_d = {q_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_ITER) begin
               state_d = S_DONE;
               quot_d  = q_d;
               rem_d   = r_d;
               dbz_d   = 1'b0;
            end else begin
               alu_a_d    = {r_d[WIDTH-2:0], q_d[WIDTH-1]};
               alu_b_d    = d_q;
               alu_ctrl_d = ALU_SUB;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   // State and datapath registers; reset aborts any division in flight.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q    <= S_IDLE;
         r_q        <= '0;
         q_q        <= '0;
         d_q        <= '0;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         quot_q     <= '0;
         rem_q      <= '0;
         dbz_q      <= 1'b0;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_ctrl_q <= ALU_ADD;
      end else begin
         state_q    <= state_d;
         r_q        <= r_d;
         q_q        <= q_d;
         d_q        <= d_d;
         cnt_q      <= cnt_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         quot_q     <= quot_d;
         rem_q      <= rem_d;
         dbz_q      <= dbz_d;
         alu_a_q    <= alu_a_d;
         alu_b_q    <= alu_b_d;
         alu_ctrl_q <= alu_ctrl_d;
      end
   end

   assign Busy        = busy_q;
   assign Done        = done_q;
   assign Quotient    = quot_q;
   assign Remainder   = rem_q;
   assign DivByZero   = dbz_q;
   assign ALU_Src_A   = alu_a_q;
   assign ALU_Src_B   = alu_b_q;
   assign ALU_Control = alu_ctrl_q;

endmodule

// File: tb/tb_alu_div_seq.sv
// tb_alu_div_seq: directed bench for alu_div_seq with a combinational ALU model
// and a scoreboard of expected division results.
module tb_alu_div_seq;

   logic        CLK;
   logic        RESET;
   logic        Start;
   logic [31:0] Dividend;
   logic [31:0] Divisor;
   logic        Busy;
   logic        Done;
   logic [31:0] Quotient;
   logic [31:0] Remainder;
   logic        DivByZero;
   logic [31:0] ALU_Src_A;
   logic [31:0] ALU_Src_B;
   logic [1:0]  ALU_Control;
   logic [31:0] ALUResult;
   logic [3:0]  ALUFlags;

   typedef struct packed {
      logic [31:0] q;
      logic [31:0] r;
      logic        dbz;
   } exp_t;

   exp_t sb_q[$];
   int   tests;
   int   fails;

   alu_div_seq dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .Start       (Start),
      .Dividend    (Dividend),
      .Divisor     (Divisor),
      .Busy        (Busy),
      .Done        (Done),
      .Quotient    (Quotient),
      .Remainder   (Remainder),
      .DivByZero   (DivByZero),
      .ALU_Src_A   (ALU_Src_A),
      .ALU_Src_B   (ALU_Src_B),
      .ALU_Control (ALU_Control),
      .ALUResult   (ALUResult),
      .ALUFlags    (ALUFlags)
   );

   // Processor ALU model: 00 ADD, 01 SUB, 10 AND, 11 OR; flags {N,Z,C,V}.
   logic [32:0] add_w;
   logic [32:0] sub_w;
   logic        carry;
   always_comb begin
      add_w = {1'b0, ALU_Src_A} + {1'b0, ALU_Src_B};
      sub_w = {1'b0, ALU_Src_A} + {1'b0, ~ALU_Src_B} + 33'd1;
      carry = 1'b0;
      case (ALU_Control)
         2'b00: begin ALUResult = add_w[31:0]; carry = add_w[32]; end
         2'b01: begin ALUResult = sub_w[31:0]; carry = sub_w[32]; end
         2'b10: ALUResult = ALU_Src_A & ALU_Src_B;
         default: ALUResult = ALU_Src_A | ALU_Src_B;
      endcase
      ALUFlags = {ALUResult[31], (ALUResult == 32'd0), carry, 1'b0};
   end

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Launch one division, follow it to Done, then score the results.
   task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input bit poke);
      exp_t e;
      exp_t got;
      int   n;
      int   sub_cycles;
      bit   seen;
      int   exp_lat;
      e.q     = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      e.r     = (b == 32'd0) ? a : a % b;
      e.dbz   = (b == 32'd0);
      exp_lat = (b == 32'd0) ? 0 : 32;
      @(negedge CLK);
      Dividend = a;
      Divisor  = b;
      Start    = 1'b1;
      sb_q.push_back(e);
      @(posedge CLK);
      n = 0;
      sub_cycles = 0;
      seen = 1'b0;
      while (!seen && n <= 40) begin
         @(negedge CLK);
         Start = poke && (n == 5);
         if (n == 0) begin
            chk({tag, "_busy_rise"}, 32'(Busy), 32'd1);
            Dividend = ~a;
            Divisor  = b + 32'd3;
         end
         if (Done) seen = 1'b1;
         else begin
            if (ALU_Control == 2'b01) sub_cycles++;
            @(posedge CLK);
            n++;
         end
      end
      Start = 1'b0;
      chk({tag, "_done_seen"}, 32'(Done), 32'd1);
      chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
      chk({tag, "_sub_cycles"}, 32'(sub_cycles), 32'(exp_lat));
      if (seen && sb_q.size() > 0) begin
         got = sb_q.pop_front();
         chk({tag, "_quotient"}, Quotient, got.q);
         chk({tag, "_remainder"}, Remainder, got.r);
         chk({tag, "_divbyzero"}, 32'(DivByZero), 32'(got.dbz));
      end
      // Start during the DONE cycle must not be queued.
      Start = poke;
      @(negedge CLK);
      Start = 1'b0;
      chk({tag, "_done_pulse"}, 32'(Done), 32'd0);
      chk({tag, "_busy_fall"}, 32'(Busy), 32'd0);
      chk({tag, "_quotient_hold"}, Quotient, e.q);
      @(negedge CLK);
      chk({tag, "_stay_idle"}, 32'(Busy), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int done_cnt;
      logic [31:0] ra;
      logic [31:0] rb;
      tests    = 0;
      fails    = 0;
      RESET    = 1'b1;
      Start    = 1'b0;
      Dividend = 32'd0;
      Divisor  = 32'd0;
      repeat (2) @(negedge CLK);
      chk("rst_busy", 32'(Busy), 32'd0);
      chk("rst_done", 32'(Done), 32'd0);
      chk("rst_quotient", Quotient, 32'd0);
      chk("rst_remainder", Remainder, 32'd0);
      chk("rst_alu_ctrl", 32'(ALU_Control), 32'd0);
      chk("rst_alu_a", ALU_Src_A, 32'd0);
      RESET = 1'b0;
      @(negedge CLK);

      run_div("basic", 32'd100, 32'd7, 1'b1);
      run_div("max_unit", 32'hFFFF_FFFF, 32'd1, 1'b0);
      run_div("msb_path", 32'hFFFF_FFFF, 32'h8000_0001, 1'b0);
      run_div("big_div", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      run_div("div_zero", 32'd5, 32'd0, 1'b1);
      ra = $urandom;
      rb = $urandom_range(1, 65535);
      run_div("rand_a", ra, rb, 1'b0);
      run_div("basic2", 32'd100, 32'd7, 1'b0);

      // Abort mid-iteration with an asynchronous reset.
      @(negedge CLK);
      Dividend = 32'd100;
      Divisor  = 32'd7;
      Start    = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      Start = 1'b0;
      repeat (9) @(posedge CLK);
      #2 RESET = 1'b1;
      #1;
      chk("abort_busy", 32'(Busy), 32'd0);
      chk("abort_done", 32'(Done), 32'd0);
      chk("abort_quotient", Quotient, 32'd0);
      chk("abort_remainder", Remainder, 32'd0);
      chk("abort_alu_ctrl", 32'(ALU_Control), 32'd0);
      @(negedge CLK);
      RESET = 1'b0;
      done_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge CLK);
         if (Done) done_cnt++;
      end
      chk("abort_no_done", 32'(done_cnt), 32'd0);
      chk("abort_idle", 32'(Busy), 32'd0);
      run_div("after_abort", 32'd100, 32'd7, 1'b0);

      chk("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
